// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   mem_state_e        : controller FSM states (IDLE, LOW, HIGH, DONE)
//   DATA_BASE_DEFAULT  : byte address that maps onto SRAM halfword 0
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_e;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side memory request bus between the EXE->MEM register and the
// MEM-stage SRAM controller.
//   mem_r_en / mem_w_en : load / store request, held while ready=0
//   addr                : word-aligned byte address (ALU result)
//   wdata               : store data (Rm value)
//   rdata               : last completed load word
//   ready               : 1 = pipeline may advance
// master = pipeline side, slave = controller side.
interface mem_sram_ctrl_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output mem_r_en, mem_w_en, addr, wdata, input rdata, ready);
  modport slave  (input mem_r_en, mem_w_en, addr, wdata, output rdata, ready);

endinterface

// File: rtl/mem_sram_ctrl_wait_cnt.sv
// sram_wait_cnt: loadable down-counter that paces each halfword SRAM cycle.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : reload with load_val (asserted on every FSM state entry)
//   load_val  : reload value (WAIT_CYCLES-1)
//   last      : counter has reached zero, i.e. final cycle of the phase
module sram_wait_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage responder that services 32-bit loads/stores as
// two halfword cycles on an external 16-bit asynchronous SRAM.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : mem_sram_ctrl_if.slave pipeline request bus
//   sram_addr   : halfword address {word index, half select}
//   sram_dq_o   : write data to the pad
//   sram_dq_oe  : pad output enable
//   sram_dq_i   : read data from the pad
//   sram_we_n   : active-low write strobe
// Optional feature macro: MEM_SRAM_READ_BUF_EN adds a single-entry load
// buffer that lets a repeated load finish without touching the SRAM.
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  mem_sram_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n
);

  localparam int IW = SRAM_AW - 1;
  localparam int CW = $clog2(WAIT_CYCLES) + 1;

  mem_state_e    state, state_next;
  logic          last;
  logic          req;
  logic [31:0]   req_off;
  logic [IW-1:0] req_idx;
  logic          unused_addr_bits;

  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [15:0]   low_hold;
  logic [31:0]   rdata_q;

  assign req     = bus.mem_r_en | bus.mem_w_en;
  // Offset from the data base wraps modulo 2^32; bits above the index are
  // dropped, which gives the intended silent wrap of out-of-range addresses.
  assign req_off = bus.addr - DATA_BASE;
  assign req_idx = req_off[IW+1:2];
  assign unused_addr_bits = ^{req_off[31:IW+2], req_off[1:0]};

`ifdef MEM_SRAM_READ_BUF_EN
  logic          buf_valid;
  logic [IW-1:0] buf_idx;
  logic [31:0]   buf_data;
  logic          buf_hit;

  // A store never takes the shortcut, even with the load enable also high.
  assign buf_hit = bus.mem_r_en & ~bus.mem_w_en & buf_valid & (buf_idx == req_idx);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req) begin
`ifdef MEM_SRAM_READ_BUF_EN
          state_next = buf_hit ? DONE : LOW;
`else
          state_next = LOW;
`endif
        end
      end
      LOW:  if (last) state_next = HIGH;
      HIGH: if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter reloads on every state entry so each phase lasts exactly
  // WAIT_CYCLES cycles regardless of the previous phase.
  sram_wait_cnt #(.WIDTH(CW)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_next != state),
    .load_val (CW'(WAIT_CYCLES - 1)),
    .last     (last)
  );

  // Pad controls are decoded from the state register, so an asynchronous
  // reset releases the write strobe and the pad driver immediately.
  always_comb begin
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    if (state == LOW || state == HIGH) begin
      sram_addr = {idx_q, (state == HIGH)};
      if (wr_q) begin
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
        sram_dq_o  = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      low_hold <= '0;
      rdata_q  <= '0;
`ifdef MEM_SRAM_READ_BUF_EN
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
`endif
    end else begin
      // Request is latched once; the pipeline is frozen until DONE anyway.
      if (state == IDLE && state_next == LOW) begin
        idx_q   <= req_idx;
        wdata_q <= bus.wdata;
        wr_q    <= bus.mem_w_en;
      end
      if (state == LOW && last && !wr_q) low_hold <= sram_dq_i;
      if (state == HIGH && last && !wr_q) begin
        rdata_q <= {sram_dq_i, low_hold};
`ifdef MEM_SRAM_READ_BUF_EN
        buf_valid <= 1'b1;
        buf_idx   <= idx_q;
        buf_data  <= {sram_dq_i, low_hold};
`endif
      end
`ifdef MEM_SRAM_READ_BUF_EN
      if (state == IDLE && bus.mem_w_en && buf_valid && buf_idx == req_idx)
        buf_data <= bus.wdata;
      if (state == IDLE && state_next == DONE)
        rdata_q <= buf_data;
`endif
    end
  end

  // The request cycle in IDLE already stalls; ready rises only in DONE.
  assign bus.ready = (state == DONE) | ((state == IDLE) & ~req);
  assign bus.rdata = rdata_q;

endmodule
